// File: rtl/display_ctrl_pkg.sv
// display_ctrl_pkg: shared types for the six-digit display and its owner scheduler
package display_ctrl_pkg;

    typedef logic [5:0][3:0] bcdPac_t;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_GAP,
        ST_OP,
        ST_SET
    } disp_state_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_O,
        SRC_S
    } disp_src_t;

    // Counter width for a modulus n, never narrower than one bit
    function automatic int cnt_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/blink_gen.sv
// blink_gen: square-wave visibility phase, BLINK_HALF cycles visible then BLINK_HALF dark
module blink_gen
    import display_ctrl_pkg::*;
#(
    parameter int BLINK_HALF = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic blink_en,
    output logic vis
);

    localparam int W = cnt_w(BLINK_HALF);
    localparam logic [W-1:0] LAST = W'(BLINK_HALF - 1);

    logic [W-1:0] cnt;

    // Free-running half-period counter; idle phase is always visible
    always_ff @(posedge clk) begin
        if (rst || !blink_en) begin
            cnt <= '0;
            vis <= 1'b1;
        end else if (cnt == LAST) begin
            cnt <= '0;
            vis <= ~vis;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/display_ctrl.sv
// display_ctrl: picks the display owner, inserts a blank gap on hand-over, idle-blanks and blinks
module display_ctrl
    import display_ctrl_pkg::*;
#(
    parameter int TIMEOUT    = 500_000_000,
    parameter int BLINK_HALF = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       setup_mode,
    input  logic       upd_o,
    input  logic       upd_s,
    input  logic       blink_en,
    output logic       enable_o,
    output logic       enable_s,
    output logic [1:0] active_src
);

    localparam int IW = cnt_w(TIMEOUT);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

    disp_state_t   state, state_nx;
    logic [IW-1:0] idle;
    logic          setup_q;
    logic          upd;
    logic          timeout;
    logic          vis;

    assign upd     = upd_o | upd_s;
    assign timeout = (idle == IDLE_LAST) && !upd;

    // State register plus the setup_mode history used for edge detection in OFF
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_OFF;
            setup_q <= 1'b0;
        end else begin
            state   <= state_nx;
            setup_q <= setup_mode;
        end
    end

    // Ownership transitions; every owner change passes through the one-cycle GAP
    always_comb begin
        state_nx = state;
        case (state)
            ST_OFF:  if (upd || (setup_mode && !setup_q)) state_nx = ST_GAP;
            ST_GAP:  state_nx = setup_mode ? ST_SET : ST_OP;
            ST_OP:   state_nx = setup_mode ? ST_GAP : (timeout ? ST_OFF : ST_OP);
            ST_SET:  if (!setup_mode) state_nx = ST_GAP;
            default: state_nx = ST_OFF;
        endcase
    end

    // Idle counter: cleared by any update or the GAP, counts only while operational, saturates
    always_ff @(posedge clk) begin
        if (rst || upd || state == ST_GAP) begin
            idle <= '0;
        end else if (state == ST_OP && idle != IDLE_LAST) begin
            idle <= idle + 1'b1;
        end
    end

    blink_gen #(
        .BLINK_HALF(BLINK_HALF)
    ) u_blink (
        .clk     (clk),
        .rst     (rst),
        .blink_en(blink_en),
        .vis     (vis)
    );

    // Enables and owner tag decode purely from registered state
    always_comb begin
        enable_o   = (state == ST_OP) && vis;
        enable_s   = (state == ST_SET) && vis;
        active_src = state == ST_OP ? SRC_O : (state == ST_SET ? SRC_S : SRC_NONE);
    end

endmodule

// File: doc/display_ctrl.md
# display_ctrl

Owner/scheduler for the six-digit `display` block. Decides which source drives the display: the operational datapath or the setup datapath. Generates its mutually exclusive `enable_o`/`enable_s` with a guaranteed blank gap on every owner change. Adds an idle-timeout blank (operational mode only) and a blink function for alarm and edit feedback.

## Interface
- `TIMEOUT`, default 500_000_000: idle cycles in operational ownership before blanking (10 s at 50 MHz); legal ≥ 2.
- `BLINK_HALF`, default 25_000_000: cycles per blink half-period; legal ≥ 1.
- `clk` in 1: single clock, all state on posedge.
- `rst` in 1: reset is synchronous and active-high.
- `setup_mode` in 1: level; 1 means setup owns the display, 0 means operational.
- `upd_o` in 1: one-cycle pulse, operational `bcdPac_t` changed.
- `upd_s` in 1: one-cycle pulse, setup `bcdPac_t` changed.
- `blink_en` in 1: level; while high the owner's enable is gated by the blink phase.
- `enable_o` out 1: to `display.enable_o`.
- `enable_s` out 1: to `display.enable_s`.
- `active_src` out `disp_src_t` (2 b): SRC_NONE / SRC_O / SRC_S, current owner.

## Operation
- States (`disp_state_t`): ST_OFF, ST_GAP, ST_OP, ST_SET.
- ST_OFF: both enables low.
  - Any `upd_o|upd_s` goes to ST_GAP.
  - `setup_mode` rising also goes to ST_GAP.
- ST_GAP: exactly one cycle, both enables low, idle counter cleared. Exit goes to ST_SET if `setup_mode`=1 (sampled in the GAP cycle), else ST_OP.
- ST_OP:
  - `setup_mode`=1 goes to ST_GAP.
  - Else, idle counter == TIMEOUT-1 with no update this cycle goes to ST_OFF.
  - Else stay.
- ST_SET: `setup_mode`=0 goes to ST_GAP. There is no timeout.
- Idle counter, width `$clog2(TIMEOUT)`:
  - Loads 0 on any `upd_o|upd_s` or in ST_GAP.
  - Otherwise increments in ST_OP and holds elsewhere.
  - Never wraps.
- Blink phase register `vis` and counter, width `$clog2(BLINK_HALF)`:
  - `blink_en`=0: `cnt`←0, `vis`←1.
  - `blink_en`=1: `cnt` increments. At `cnt`==BLINK_HALF-1, `cnt`←0 and `vis`←~`vis`.
  - The counter runs independently of state.
- Output decode, from registers only (no input-to-output combinational path):
  - `enable_o` = (ST_OP) & `vis`.
  - `enable_s` = (ST_SET) & `vis`.
  - `active_src` = SRC_O in ST_OP, SRC_S in ST_SET, SRC_NONE otherwise.
- Invariant: `enable_o` & `enable_s` never both 1, in any cycle.
- Priority, same cycle:
  - Mode change beats timeout.
  - Update beats timeout.
  - `rst` beats everything.

## Timing
- Reset values: state ST_OFF, `enable_o`=`enable_s`=0, `active_src`=SRC_NONE, idle counter 0, blink counter 0, `vis`=1.
- Reset mid-operation: outputs at reset values from the cycle after the `rst` edge.
- Wake-up: update pulse at cycle t in ST_OFF gives ST_GAP at t+1 and the owner enable high from t+2.
- Owner change: `setup_mode` toggles at t in ST_OP/ST_SET. Old enable is low from t+1 (GAP), new enable is high from t+2.
- Timeout: last update at t in ST_OP. `enable_o` is high through t+TIMEOUT and low from t+TIMEOUT+1.
- Blink: `blink_en` rises at t. Visible t..t+B-1, dark t+B..t+2B-1, repeating (B = BLINK_HALF). If `blink_en` falls in a dark phase, the enable returns the next cycle.
- Updates during a dark phase or ST_GAP still clear the idle counter.
- The display latches packets only while enabled. Sources hold `bcdPac_t` levels, so latching resumes in the next visible phase.

## Structure
- `disp_state_t` and `disp_src_t` enums go in the shared types package (`Tipos.sv`), alongside `bcdPac_t`.
- The FSM and idle counter live in `display_ctrl`.
- Sub-module `blink_gen` (params BLINK_HALF; ports clk, rst, `blink_en` → `vis`) is a natural split and reusable for LED feedback.

## Test plan
Benches run with TIMEOUT=8, BLINK_HALF=3.
- Reset and wake: `rst` high for 2 cycles, giving enables 0 and SRC_NONE. Then `upd_o` at t with `setup_mode`=0 gives `enable_o`=0 at t+1 and `enable_o`=1 with SRC_O from t+2.
- Timeout and extend:
  - `upd_o` at t in ST_OP: `enable_o` is 1 through t+8 and 0 at t+9.
  - Repeat with a second `upd_o` at t+5: `enable_o` falls at t+14.
- Owner switch: in ST_OP, `setup_mode` goes 0→1 at t. Both enables are 0 at t+1 and `enable_s`=1 from t+2. Assert the never-both-high invariant every cycle.
- Setup holds: in ST_SET, 100 cycles with no update keeps `enable_s`=1 and `active_src`=SRC_S.
- Blink:
  - In ST_OP with `blink_en`=1, `enable_o` runs 1,1,1,0,0,0 repeating.
  - Dropping `blink_en` during a dark cycle gives `enable_o`=1 the next cycle.
- Collisions:
  - `upd_o` on the timeout cycle keeps ST_OP.
  - `setup_mode` rising on the timeout cycle gives GAP then `enable_s`.
  - `rst` in ST_SET gives enables 0 and SRC_NONE next cycle.
